// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the bus-controller front end.
package bus_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DATA_W   = 16;
  localparam int NREQ_MAX = 8;

  function automatic logic [NREQ_MAX-1:0] idx_to_onehot(input logic [2:0] idx);
    logic [NREQ_MAX-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            found,
  output logic [2:0]      idx
);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_masked;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit search over bits >= ptr.
  assign w_dbl    = {req, req};
  assign w_masked = w_dbl & ({(2*NREQ){1'b1}} << ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 2*NREQ-1; i >= 0; i--) begin
      if (w_masked[i]) begin
        found = 1'b1;
        idx   = 3'(i % NREQ);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin burst arbiter feeding the single bus-controller data_in port.
module bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        last,
  input  logic [NREQ*DATA_W-1:0] data_req,
  input  logic                   ready,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      bus_data,
  output logic                   bus_valid,
  output logic [2:0]             grant_id,
  output logic                   busy
);
  import bus_ctrl_pkg::*;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [2:0]      r_gid;
  logic [7:0]      r_cnt;
  logic [2:0]      r_ptr;

  logic            w_found;
  logic [2:0]      w_idx;
  logic            w_reqg;
  logic            w_lastg;
  logic            w_acc;
  logic            w_max;
  logic            w_rel;
  logic [7:0]      w_cnt_nxt;
  logic [2:0]      w_ptr_nxt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // r_gnt is zero outside GRANT, so masking with it selects the owner.
  assign w_reqg    = |(req & r_gnt);
  assign w_lastg   = |(last & r_gnt);
  assign ack       = req & r_gnt & {NREQ{ready}};
  assign w_acc     = |ack;
  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_max     = (w_cnt_nxt == 8'(MAX_BURST));
  assign w_rel     = (r_state == GRANT) & (~w_reqg | (w_acc & (w_lastg | w_max)));
  assign w_ptr_nxt = (r_gid == 3'(NREQ-1)) ? 3'd0 : r_gid + 3'd1;

  assign gnt       = r_gnt;
  assign grant_id  = r_gid;
  assign busy      = (r_state == GRANT);
  assign bus_valid = w_reqg;

  always_comb begin
    bus_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i] & req[i]) bus_data = data_req[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_gnt   <= NREQ'(idx_to_onehot(w_idx));
            r_gid   <= w_idx;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_rel) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_gid   <= '0;
            r_cnt   <= '0;
            r_ptr   <= w_ptr_nxt;
          end else if (w_acc) begin
            r_cnt   <= w_cnt_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter against a transaction-level ownership model.
module tb_bus_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int MAXB = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req, last, gnt, ack;
  logic [NREQ*DW-1:0]   data_req;
  logic                 ready;
  logic [DW-1:0]        bus_data;
  logic                 bus_valid;
  logic [2:0]           grant_id;
  logic                 busy;

  int n_chk = 0;
  int n_err = 0;

  // Model: who owns the bus (-1 = nobody), beats accepted, next search start.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int n_maxrel = 0;

  logic [NREQ-1:0]    t_rq, t_lst;
  logic               t_rdy, t_rst;
  logic [NREQ*DW-1:0] t_dat;

  always #5 clk = ~clk;

  bus_arbiter #(.NREQ(NREQ), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .data_req  (data_req),
    .ready     (ready),
    .gnt       (gnt),
    .ack       (ack),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic rst, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] lst,
                      input logic [NREQ*DW-1:0] dat, input logic rdy);
    logic [31:0] e_gnt, e_ack, e_data, e_gid;
    logic        e_valid, e_busy;
    @(negedge clk);
    reset = rst; req = rq; last = lst; data_req = dat; ready = rdy;
    #1;
    e_busy  = (m_owner >= 0);
    e_gnt   = e_busy ? (32'd1 << m_owner) : 32'd0;
    e_gid   = e_busy ? 32'(m_owner) : 32'd0;
    e_valid = e_busy && rq[m_owner];
    e_data  = e_valid ? 32'(dat[m_owner*DW +: DW]) : 32'd0;
    e_ack   = (e_valid && rdy) ? e_gnt : 32'd0;
    chk("gnt",       32'(gnt),       e_gnt);
    chk("ack",       32'(ack),       e_ack);
    chk("bus_data",  32'(bus_data),  e_data);
    chk("bus_valid", 32'(bus_valid), 32'(e_valid));
    chk("grant_id",  32'(grant_id),  e_gid);
    chk("busy",      32'(busy),      32'(e_busy));
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_beats = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_owner < 0 && rq[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          m_beats = 0;
        end
      end
    end else if (!rq[m_owner]) begin
      m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
    end else if (rdy) begin
      m_beats++;
      if (m_beats == MAXB) n_maxrel++;
      if (lst[m_owner] || m_beats == MAXB) begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; last = '0; data_req = '0; ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then a short 3-word burst from requester 0.
    step(1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    step(1'b0, 4'b0001, 4'b0000, 64'h0000_0000_0000_FBA0, 1'b1);
    step(1'b0, 4'b0001, 4'b0000, 64'h0000_0000_0000_FBA0, 1'b1);
    step(1'b0, 4'b0001, 4'b0000, 64'h0000_0000_0000_F0A1, 1'b1);
    step(1'b0, 4'b0001, 4'b0001, 64'h0000_0000_0000_F102, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, '0, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, '0, 1'b1);

    // Random phases: mixed, full round-robin, long bursts, heavy backpressure.
    t_rq = '0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 700; c++) begin
        for (int i = 0; i < NREQ; i++) begin
          case (ph)
            0:       if ($urandom_range(7) == 0) t_rq[i] = ~t_rq[i];
            1:       t_rq[i] = 1'b1;
            2:       t_rq[i] = ($urandom_range(31) != 0);
            default: if ($urandom_range(5) == 0) t_rq[i] = ~t_rq[i];
          endcase
          t_lst[i] = (ph == 1) ? 1'b1 : (ph == 2) ? ($urandom_range(15) == 0)
                                                  : ($urandom_range(3) == 0);
        end
        t_rdy = (ph == 1) ? 1'b1 : (ph == 3) ? ($urandom_range(3) == 0)
                                             : ($urandom_range(7) != 0);
        t_rst = (ph != 1) && ($urandom_range(199) == 0);
        t_dat = {$urandom, $urandom};
        step(t_rst, t_rq, t_lst, t_dat, t_rdy);
      end
    end

    if (n_maxrel == 0) begin
      n_err++;
      $display("FAIL max_burst_cov: got 0 forced releases expected at least 1");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
